cdb_arbiter: RTL and testbench

Common Data Bus arbiter for the superscalar back end. It sits between the four execution units (integer ALU, multiplier, divider, load/store) and the single CDB that feeds the issue queues, register status table and reorder logic. Each unit gets a one-entry holding register so it can hand off a result and move on. A registered grant stage broadcasts at most one result (tag plus data) per cycle.

---
 rtl/cdb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: four one-entry holding registers feeding a registered single-result broadcast.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority div > mul > mem > int.
module cdb_arbiter #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_cdb_req,
    input  logic              mul_cdb_req,
    input  logic              div_cdb_req,
    input  logic              mem_cdb_req,
    input  logic [TAG_W-1:0]  int_cdb_tag,
    input  logic [TAG_W-1:0]  mul_cdb_tag,
    input  logic [TAG_W-1:0]  div_cdb_tag,
    input  logic [TAG_W-1:0]  mem_cdb_tag,
    input  logic [DATA_W-1:0] int_cdb_data,
    input  logic [DATA_W-1:0] mul_cdb_data,
    input  logic [DATA_W-1:0] div_cdb_data,
    input  logic [DATA_W-1:0] mem_cdb_data,
    output logic              int_cdb_ack,
    output logic              mul_cdb_ack,
    output logic              div_cdb_ack,
    output logic              mem_cdb_ack,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_busy
);

    logic [3:0]        w_req;
    logic [TAG_W-1:0]  w_tag  [4];
    logic [DATA_W-1:0] w_data [4];
    logic [3:0]        w_grant;
    logic [3:0]        w_ack;
    logic [1:0]        w_gnt_idx;
    logic              w_any_grant;

    logic [3:0]        r_hold_valid;
    logic [TAG_W-1:0]  r_hold_tag  [4];
    logic [DATA_W-1:0] r_hold_data [4];
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;

    assign w_req     = {mem_cdb_req, div_cdb_req, mul_cdb_req, int_cdb_req};
    assign w_tag[0]  = int_cdb_tag;
    assign w_tag[1]  = mul_cdb_tag;
    assign w_tag[2]  = div_cdb_tag;
    assign w_tag[3]  = mem_cdb_tag;
    assign w_data[0] = int_cdb_data;
    assign w_data[1] = mul_cdb_data;
    assign w_data[2] = div_cdb_data;
    assign w_data[3] = mem_cdb_data;

    assign w_any_grant = |r_hold_valid;

`ifdef CDB_ROUND_ROBIN_EN
    logic [1:0] r_rr_ptr;
    logic [3:0] w_rot;
    logic [1:0] w_ofs;

    // Rotate the valid vector so bit k is the hold at rr_ptr+k.
    always_comb begin
        w_rot = r_hold_valid;
        case (r_rr_ptr)
            2'd0:    w_rot = r_hold_valid;
            2'd1:    w_rot = {r_hold_valid[0],   r_hold_valid[3:1]};
            2'd2:    w_rot = {r_hold_valid[1:0], r_hold_valid[3:2]};
            2'd3:    w_rot = {r_hold_valid[2:0], r_hold_valid[3]};
            default: w_rot = r_hold_valid;
        endcase
    end

    // First valid hold at or after the pointer.
    always_comb begin
        w_ofs = 2'd0;
        casez (w_rot)
            4'b???1: w_ofs = 2'd0;
            4'b??10: w_ofs = 2'd1;
            4'b?100: w_ofs = 2'd2;
            4'b1000: w_ofs = 2'd3;
            default: w_ofs = 2'd0;
        endcase
    end

    assign w_gnt_idx = r_rr_ptr + w_ofs;

    // Pointer moves just past the requester that won this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_any_grant) begin
            r_rr_ptr <= w_gnt_idx + 2'd1;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    // Fixed priority: long-latency units (div, mul) drain first, int last.
    always_comb begin
        w_gnt_idx = 2'd0;
        casez ({r_hold_valid[2], r_hold_valid[1], r_hold_valid[3], r_hold_valid[0]})
            4'b1???: w_gnt_idx = 2'd2;
            4'b01??: w_gnt_idx = 2'd1;
            4'b001?: w_gnt_idx = 2'd3;
            4'b0001: w_gnt_idx = 2'd0;
            default: w_gnt_idx = 2'd0;
        endcase
    end
`endif

    assign w_grant = w_any_grant ? (4'b0001 << w_gnt_idx) : 4'b0000;
    // A hold being drained this cycle can take a new result in the same edge.
    assign w_ack   = {4{reset}} | ~r_hold_valid | w_grant;

    // Holding registers: accept wins over drain so grant+accept stays full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_valid <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_hold_tag[i]  <= {TAG_W{1'b0}};
                r_hold_data[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_req[i] && w_ack[i]) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_tag[i]   <= w_tag[i];
                    r_hold_data[i]  <= w_data[i];
                end else if (w_grant[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end else begin
                    r_hold_valid[i] <= r_hold_valid[i];
                end
            end
        end
    end

    // Broadcast register; tag/data keep their last values when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= {TAG_W{1'b0}};
            r_cdb_data  <= {DATA_W{1'b0}};
        end else if (w_any_grant) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_hold_tag[w_gnt_idx];
            r_cdb_data  <= r_hold_data[w_gnt_idx];
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign int_cdb_ack = w_ack[0];
    assign mul_cdb_ack = w_ack[1];
    assign div_cdb_ack = w_ack[2];
    assign mem_cdb_ack = w_ack[3];
    assign cdb_valid   = r_cdb_valid;
    assign cdb_tag     = r_cdb_tag;
    assign cdb_data    = r_cdb_data;
    assign cdb_busy    = |r_hold_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a pending-result model predicts acks and broadcast order.
module tb_cdb_arbiter;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } bcast_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        d_req = 4'b0000;
    logic [TAG_W-1:0]  d_tag  [4];
    logic [DATA_W-1:0] d_data [4];
    logic              int_ack, mul_ack, div_ack, mem_ack;
    logic              cdb_valid, cdb_busy;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    always #5 clk = ~clk;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .int_cdb_req(d_req[0]), .mul_cdb_req(d_req[1]),
        .div_cdb_req(d_req[2]), .mem_cdb_req(d_req[3]),
        .int_cdb_tag(d_tag[0]), .mul_cdb_tag(d_tag[1]),
        .div_cdb_tag(d_tag[2]), .mem_cdb_tag(d_tag[3]),
        .int_cdb_data(d_data[0]), .mul_cdb_data(d_data[1]),
        .div_cdb_data(d_data[2]), .mem_cdb_data(d_data[3]),
        .int_cdb_ack(int_ack), .mul_cdb_ack(mul_ack),
        .div_cdb_ack(div_ack), .mem_cdb_ack(mem_ack),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_busy(cdb_busy)
    );

    // Reference model: which units have a result waiting, and whose turn it is.
    bit     m_pv   [4];
    bcast_t m_pend [4];
    bit     m_acc  [4];
    int     m_ptr = 0;
    bcast_t m_last = '0;
    bcast_t exp_q [$];
    logic [TAG_W-1:0] seen_tags [$];
    int n_cmp = 0;
    int n_fail = 0;

    function automatic int pick();
`ifdef CDB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++)
            if (m_pv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
        int order [4] = '{2, 1, 3, 0};
        for (int k = 0; k < 4; k++)
            if (m_pv[order[k]]) return order[k];
`endif
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_pv[i] = 1'b0; m_acc[i] = 1'b0; m_pend[i] = '0;
            d_tag[i] = '0; d_data[i] = '0;
        end
    end

    // Model update at each clock edge, from its own state and the driven inputs.
    always @(posedge clk) begin
        int g;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin m_pv[i] = 1'b0; m_acc[i] = 1'b0; end
            m_ptr = 0;
            m_last = '0;
        end else begin
            g = pick();
            if (g >= 0) begin
                exp_q.push_back(m_pend[g]);
                m_last = m_pend[g];
                m_ptr = (g + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = d_req[i] && (!m_pv[i] || g == i);
                if (m_acc[i]) begin
                    m_pv[i] = 1'b1;
                    m_pend[i] = {d_tag[i], d_data[i]};
                end else if (g == i) begin
                    m_pv[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: compare acks, busy and the broadcast against the model on the falling edge.
    always @(negedge clk) begin
        int g;
        logic [3:0] eack;
        bcast_t e;
        bit busy;
        g = pick();
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eack[i] = reset || !m_pv[i] || (g == i);
            busy = busy | m_pv[i];
        end
        chk("ack", {60'd0, mem_ack, div_ack, mul_ack, int_ack}, {60'd0, eack});
        chk("busy", {63'd0, cdb_busy}, {63'd0, busy});
        chk("valid", {63'd0, cdb_valid}, {63'd0, exp_q.size() != 0});
        if (cdb_valid) seen_tags.push_back(cdb_tag);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bcast", {26'd0, cdb_tag, cdb_data}, {26'd0, e.tag, e.data});
        end else begin
            chk("idle_hold", {26'd0, cdb_tag, cdb_data}, {26'd0, m_last.tag, m_last.data});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (m_acc[i]) d_req[i] = 1'b0;
    endtask

    task automatic present(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        d_req[i] = 1'b1; d_tag[i] = t; d_data[i] = d;
    endtask

    function automatic logic [7:0] seen_at(input int k);
        if (k < seen_tags.size()) return {2'b00, seen_tags[k]};
        return 8'hFF;
    endfunction

    initial begin
        logic [TAG_W-1:0] exp4 [4];
        int cnt;
`ifdef CDB_ROUND_ROBIN_EN
        exp4 = '{6'd1, 6'd2, 6'd3, 6'd4};
`else
        exp4 = '{6'd3, 6'd2, 6'd4, 6'd1};
`endif
        // Reset then idle
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_tag", {58'd0, cdb_tag}, 64'd0);
        chk("rst_data", {32'd0, cdb_data}, 64'd0);

        // Single result, two-cycle latency
        seen_tags.delete();
        present(0, 6'h05, 32'hDEADBEEF);
        repeat (4) step();
        chk("single_cnt", 64'(seen_tags.size()), 64'd1);
        chk("single_tag", {56'd0, seen_at(0)}, 64'h05);

        // Four simultaneous results from a fresh pointer
        reset = 1'b1; step(); reset = 1'b0;
        seen_tags.delete();
        for (int i = 0; i < 4; i++) present(i, 6'(i + 1), $urandom);
        repeat (7) step();
        for (int k = 0; k < 4; k++) chk("order4", {56'd0, seen_at(k)}, {58'd0, exp4[k]});

        // Backpressure on int while all holds are full
        seen_tags.delete();
        for (int i = 0; i < 4; i++) present(i, 6'h31 + 6'(i), $urandom);
        step();
        present(0, 6'h10, 32'h1234_5678);
        for (int t = 0; t < 10 && d_req[0]; t++) step();
        chk("bp_accepted", {63'd0, d_req[0]}, 64'd0);
        repeat (6) step();
        cnt = 0;
        foreach (seen_tags[k]) if (seen_tags[k] == 6'h10) cnt++;
        chk("bp_once", 64'(cnt), 64'd1);
        chk("bp_total", 64'(seen_tags.size()), 64'd5);

        // Back-to-back streaming from mul
        seen_tags.delete();
        for (int k = 0; k < 8; k++) begin
            present(1, 6'h20 + 6'(k), $urandom);
            step();
            chk("stream_acc", {63'd0, d_req[1]}, 64'd0);
        end
        repeat (4) step();
        for (int k = 0; k < 8; k++) chk("stream_tag", {56'd0, seen_at(k)}, 64'h20 + 64'(k));

        // Reset mid-operation discards held results; requests in the reset cycle are dropped
        seen_tags.delete();
        present(0, 6'h3A, $urandom);
        present(1, 6'h3B, $urandom);
        present(3, 6'h3C, $urandom);
        step();
        reset = 1'b1;
        present(2, 6'h3F, $urandom);
        step();
        reset = 1'b0;
        d_req = 4'b0000;
        chk("post_rst_valid", {63'd0, cdb_valid}, 64'd0);
        repeat (5) step();
        chk("post_rst_cnt", 64'(seen_tags.size()), 64'd0);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                if (!d_req[i] && $urandom_range(0, 2) != 0)
                    present(i, 6'($urandom), $urandom);
            step();
        end
        reset = 1'b0;
        for (int t = 0; t < 40 && d_req != 4'b0000; t++) step();
        chk("drain_req", {60'd0, d_req}, 64'd0);
        repeat (8) step();
        chk("drain_q", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
